// File: rtl/mlp_weight_update_if.sv
// Handshake, error/pixel inputs and weight read-back port of mlp_weight_update.
interface mlp_weight_update_if #(
  parameter int W    = 8,
  parameter int N_IN = 25
);
  localparam int AW = $clog2(N_IN + 1);

  logic                 start;
  logic signed [W-1:0]  err_in;
  logic [N_IN-1:0]      x_in;
  logic                 busy;
  logic                 done;
  logic [AW-1:0]        w_rd_addr;
  logic signed [W-1:0]  w_rd_data;
  logic [15:0]          upd_count;

  modport master (
    output start, err_in, x_in, w_rd_addr,
    input  busy, done, w_rd_data, upd_count
  );

  modport slave (
    input  start, err_in, x_in, w_rd_addr,
    output busy, done, w_rd_data, upd_count
  );
endinterface

// File: rtl/mlp_weight_update.sv
// Single-layer perceptron weight update: w[i] += (err >>> LR_SHIFT) for set pixels, plus bias.
// Optional macro MLP_UPD_SAT_EN: saturate weight sums instead of wrapping.
module mlp_weight_update #(
  parameter int W        = 8,
  parameter int FRAC     = 6,
  parameter int N_IN     = 25,
  parameter int LR_SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mlp_weight_update_if.slave  bus
);
  localparam int AW = $clog2(N_IN + 1);

  if (FRAC < 0 || FRAC >= W) begin : g_frac_check
    $error("FRAC must lie in [0, W-1]");
  end

  typedef enum logic [1:0] {IDLE, UPD, BIAS, DONE} state_t;

  state_t               state, state_nxt;
  logic [AW-1:0]        idx;
  logic signed [W-1:0]  err_lat;
  logic [N_IN-1:0]      x_lat;
  logic signed [W-1:0]  w [0:N_IN];
  logic signed [W-1:0]  delta;
  logic [AW-1:0]        wr_addr;
  logic                 wr_en;
  logic signed [W:0]    sum;
  logic signed [W-1:0]  sum_fit;
  logic                 done_q;
  logic [15:0]          cnt;
  logic signed [W-1:0]  rd_q;

  assign delta = err_lat >>> LR_SHIFT;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.err_in != '0) ? UPD : DONE;
      UPD:  if (idx == AW'(N_IN - 1)) state_nxt = BIAS;
      BIAS: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One shared adder: pixel weight during UPD, bias weight during BIAS.
  always_comb begin
    wr_addr = (state == BIAS) ? AW'(N_IN) : idx;
    wr_en   = ((state == UPD) && x_lat[idx]) || (state == BIAS);
    sum     = {w[wr_addr][W-1], w[wr_addr]} + {delta[W-1], delta};
`ifdef MLP_UPD_SAT_EN
    if (sum[W] != sum[W-1])
      sum_fit = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      sum_fit = sum[W-1:0];
`else
    sum_fit = sum[W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= unsigned'(N_IN); i++) w[i] <= '0;
      idx     <= '0;
      err_lat <= '0;
      x_lat   <= '0;
      done_q  <= 1'b0;
      cnt     <= '0;
      rd_q    <= '0;
    end else begin
      // done trails the DONE state by one edge, so the pulse lands in IDLE.
      done_q <= (state == DONE);
      // Nonblocking read yields the pre-write value on a same-edge hit.
      rd_q   <= (bus.w_rd_addr <= AW'(N_IN)) ? w[bus.w_rd_addr] : '0;
      if (wr_en) w[wr_addr] <= sum_fit;
      case (state)
        IDLE: if (bus.start) begin
          err_lat <= bus.err_in;
          x_lat   <= bus.x_in;
          idx     <= '0;
          if (bus.err_in != '0 && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
        end
        UPD: idx <= (idx == AW'(N_IN - 1)) ? '0 : idx + AW'(1);
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.w_rd_data = rd_q;
  assign bus.upd_count = cnt;
endmodule
